// File: rtl/vga_sync_gen.sv
// Raster timing generator: x/y counters advanced by pixel_tick, registered syncs/video_on, line/frame strobes.
// Optional VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame counter output frame_cnt.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pixel_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_tick,
  output logic             frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             x_last;
  logic             y_last;
  logic             h_active;
  logic             v_active;

  assign x_last = (x == H_LAST);
  assign y_last = (y == V_LAST);

  always_comb begin
    x_next = x + 1'b1;
    y_next = y;
    if (x_last) begin
      x_next = '0;
      y_next = y_last ? '0 : y + 1'b1;
    end
  end

  // Syncs and video_on decode the next position so they line up with x/y.
  assign h_active = (x_next >= H_SYNC_ON) && (x_next < H_SYNC_OFF);
  assign v_active = (y_next >= V_SYNC_ON) && (y_next < V_SYNC_OFF);

  assign line_tick  = reset_n & pixel_tick & x_last;
  assign frame_tick = line_tick & y_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
    end else if (pixel_tick) begin
      x        <= x_next;
      y        <= y_next;
      hsync    <= h_active ? SYNC_POL : ~SYNC_POL;
      vsync    <= v_active ? SYNC_POL : ~SYNC_POL;
      video_on <= (x_next < H_VIS) && (y_next < V_VIS);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
